// File: rtl/pwm_edge_calc_mc_pkg.sv
// rtl/pwm_edge_calc_mc_pkg.sv - shared types and constants for the PWM edge calculator
// Holds the controller state encoding, the pipeline depth, the MODE encodings
// and the group-count helper used by both the design and its bench.
package pwm_calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // S1 register, S2 register, S3 fold landing in the shadow table.
    localparam int PIPE_LATENCY = 3;

    localparam logic MODE_CENTER = 1'b0;
    localparam logic MODE_LEAD   = 1'b1;

    // Number of lane groups needed to cover every channel.
    function automatic int calc_groups(input int depth, input int lanes);
        return (depth + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/pwm_edge_calc_mc_if.sv
// rtl/pwm_edge_calc_mc_if.sv - control handshake bundle for the PWM edge calculator
// UPDATE/MODE : start request and alignment mode, driven by the register bank
// BUSY/DONE   : computation in flight / one-cycle commit pulse, driven by the calculator
interface pwm_edge_calc_mc_if;
    logic UPDATE;
    logic MODE;
    logic BUSY;
    logic DONE;

    modport master (output UPDATE, output MODE, input BUSY, input DONE);
    modport slave  (input UPDATE, input MODE, output BUSY, output DONE);
endinterface

// File: rtl/pwm_edge_calc_mc_lane.sv
// rtl/pwm_edge_calc_mc_lane.sv - one lane of the edge pipeline (S1, S2 registered; S3 fold combinational)
// Ports: CLK, RST_N; mode; cyc/duty/phase of the issued channel;
//        left/right/over are the folded edges, valid two clocks after issue.
// Option: PWM_DUTY_CLAMP_EN limits the duty to the period before edge placement.
module pwm_edge_lane
    import pwm_calc_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             mode,
    input  logic [WIDTH-1:0] cyc,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] phase,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             over
);

    // Two guard bits keep s + d and s - d/2 exact without overflow.
    localparam int SW = WIDTH + 2;
    typedef logic signed [SW-1:0] sval_t;

    sval_t cyc_s, duty_s, ph_s, d1, s_c, dh_c;
    sval_t s1_s, s1_dh, s1_dl, s1_d, s1_cyc;
    sval_t s2_l, s2_r, s2_cyc;
    sval_t l_c, r_c;
    sval_t lf, rf;
    logic  of;

    assign cyc_s  = $signed({2'b00, cyc});
    assign duty_s = $signed({2'b00, duty});
    assign ph_s   = $signed({2'b00, phase});

`ifdef PWM_DUTY_CLAMP_EN
    assign d1 = (duty_s > cyc_s) ? cyc_s : duty_s;
`else
    assign d1 = duty_s;
`endif

    // Phase outside (0, cycle) means no shift.
    assign s_c  = (phase != '0 && phase < cyc) ? cyc_s - ph_s : '0;
    assign dh_c = d1 >>> 1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_s   <= '0;
            s1_dh  <= '0;
            s1_dl  <= '0;
            s1_d   <= '0;
            s1_cyc <= '0;
        end else begin
            s1_s   <= s_c;
            s1_dh  <= dh_c;
            s1_dl  <= d1 - dh_c;
            s1_d   <= d1;
            s1_cyc <= cyc_s;
        end
    end

    assign l_c = (mode == MODE_LEAD) ? s1_s : s1_s - s1_dh;
    assign r_c = (mode == MODE_LEAD) ? s1_s + s1_d : s1_s + s1_dl;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_l   <= '0;
            s2_r   <= '0;
            s2_cyc <= '0;
        end else begin
            s2_l   <= l_c;
            s2_r   <= r_c;
            s2_cyc <= s1_cyc;
        end
    end

    // Single fold into [0, cycle-1]; a zero period pins both edges at 0.
    always_comb begin
        lf = s2_l;
        rf = s2_r;
        of = 1'b0;
        if (s2_cyc == '0) begin
            lf = '0;
            rf = '0;
        end else if (s2_l < 0) begin
            lf = s2_l + s2_cyc;
            of = 1'b1;
        end else if (s2_r >= s2_cyc) begin
            rf = s2_r - s2_cyc;
            of = 1'b1;
        end
    end

    logic unused_hi;
    assign unused_hi = ^{lf[SW-1:WIDTH], rf[SW-1:WIDTH]};

    assign left  = lf[WIDTH-1:0];
    assign right = rf[WIDTH-1:0];
    assign over  = of;

endmodule

// File: rtl/pwm_edge_calc_mc.sv
// rtl/pwm_edge_calc_mc.sv - double-buffered multi-lane PWM edge calculator
// Ports: CLK, RST_N (async, active low); ctl (UPDATE/MODE in, BUSY/DONE out);
//        CYCLE/DUTY/PHASE per-channel inputs; OVER/LEFT/RIGHT committed edge table.
// Option: PWM_DUTY_CLAMP_EN (see pwm_edge_lane) clamps duty to the period.
module pwm_edge_calc_mc
    import pwm_calc_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249,
    parameter int LANES = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    pwm_edge_calc_mc_if.slave    ctl,
    input  logic [WIDTH-1:0]     CYCLE [DEPTH],
    input  logic [WIDTH-1:0]     DUTY  [DEPTH],
    input  logic [WIDTH-1:0]     PHASE [DEPTH],
    output logic [DEPTH-1:0]     OVER,
    output logic [WIDTH-1:0]     LEFT  [DEPTH],
    output logic [WIDTH-1:0]     RIGHT [DEPTH]
);

    localparam int G        = calc_groups(DEPTH, LANES);
    localparam int N        = G * LANES;
    // RUN covers G issue cycles plus the two cycles for the last group to land in shadow.
    localparam int LAST_CNT = G + PIPE_LATENCY - 2;
    localparam int CW       = $clog2(LAST_CNT + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            capture, issue, commit;
    logic            snap_mode;
    logic            vld1, vld2;
    logic [CW-1:0]   grp1, grp2;
    logic            done_q;

    logic [WIDTH-1:0] snap_cyc  [N];
    logic [WIDTH-1:0] snap_duty [N];
    logic [WIDTH-1:0] snap_ph   [N];
    logic [WIDTH-1:0] lane_l    [LANES];
    logic [WIDTH-1:0] lane_r    [LANES];
    logic [LANES-1:0] lane_over;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (ctl.UPDATE) state_nxt = ST_RUN;
            ST_RUN:    if (cnt == CW'(LAST_CNT)) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign capture  = (state == ST_IDLE) && ctl.UPDATE;
    assign issue    = (state == ST_RUN) && (cnt < CW'(G));
    assign commit   = (state == ST_COMMIT);
    assign ctl.BUSY = (state != ST_IDLE);
    assign ctl.DONE = done_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= '0;
            snap_mode <= 1'b0;
            vld1      <= 1'b0;
            vld2      <= 1'b0;
            grp1      <= '0;
            grp2      <= '0;
            done_q    <= 1'b0;
        end else begin
            cnt    <= (state == ST_RUN) ? cnt + 1'b1 : '0;
            vld1   <= issue;
            grp1   <= cnt;
            vld2   <= vld1;
            grp2   <= grp1;
            done_q <= commit;
            if (capture) snap_mode <= ctl.MODE;
        end
    end

    // Snapshot is a group-wide shift register: lanes always read entries 0..LANES-1,
    // and each issue shifts the next group into place. Padding entries hold 0.
    for (genvar i = 0; i < N; i++) begin : g_snap
        logic [WIDTH-1:0] cyc_q, duty_q, ph_q;
        logic [WIDTH-1:0] cyc_new, duty_new, ph_new;
        logic [WIDTH-1:0] cyc_nxt, duty_nxt, ph_nxt;

        if (i < DEPTH) begin : g_load
            assign cyc_new  = CYCLE[i];
            assign duty_new = DUTY[i];
            assign ph_new   = PHASE[i];
        end else begin : g_pad
            assign cyc_new  = '0;
            assign duty_new = '0;
            assign ph_new   = '0;
        end

        if (i + LANES < N) begin : g_shift
            assign cyc_nxt  = snap_cyc[i + LANES];
            assign duty_nxt = snap_duty[i + LANES];
            assign ph_nxt   = snap_ph[i + LANES];
        end else begin : g_tail
            assign cyc_nxt  = '0;
            assign duty_nxt = '0;
            assign ph_nxt   = '0;
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cyc_q  <= '0;
                duty_q <= '0;
                ph_q   <= '0;
            end else if (capture) begin
                cyc_q  <= cyc_new;
                duty_q <= duty_new;
                ph_q   <= ph_new;
            end else if (issue) begin
                cyc_q  <= cyc_nxt;
                duty_q <= duty_nxt;
                ph_q   <= ph_nxt;
            end
        end

        assign snap_cyc[i]  = cyc_q;
        assign snap_duty[i] = duty_q;
        assign snap_ph[i]   = ph_q;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pwm_edge_lane #(.WIDTH(WIDTH)) u_lane (
            .CLK   (CLK),
            .RST_N (RST_N),
            .mode  (snap_mode),
            .cyc   (snap_cyc[l]),
            .duty  (snap_duty[l]),
            .phase (snap_ph[l]),
            .left  (lane_l[l]),
            .right (lane_r[l]),
            .over  (lane_over[l])
        );
    end

    // Shadow captures the S3 result of its own group; the visible table only
    // moves on commit so downstream never sees a partial update.
    for (genvar ch = 0; ch < DEPTH; ch++) begin : g_chan
        localparam int GI = ch / LANES;
        localparam int LI = ch % LANES;
        logic [WIDTH-1:0] sh_l, sh_r, out_l, out_r;
        logic             sh_o, out_o;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sh_l  <= '0;
                sh_r  <= '0;
                sh_o  <= 1'b0;
                out_l <= '0;
                out_r <= '0;
                out_o <= 1'b0;
            end else begin
                if (vld2 && grp2 == CW'(GI)) begin
                    sh_l <= lane_l[LI];
                    sh_r <= lane_r[LI];
                    sh_o <= lane_over[LI];
                end
                if (commit) begin
                    out_l <= sh_l;
                    out_r <= sh_r;
                    out_o <= sh_o;
                end
            end
        end

        assign LEFT[ch]  = out_l;
        assign RIGHT[ch] = out_r;
        assign OVER[ch]  = out_o;
    end

endmodule

// File: tb/tb_pwm_edge_calc_mc.sv
// tb/tb_pwm_edge_calc_mc.sv - directed scoreboard bench for pwm_edge_calc_mc
module tb_pwm_edge_calc_mc;
    import pwm_calc_pkg::*;

    localparam int WIDTH = 13;
    localparam int DEPTH = 249;
    localparam int LANES = 4;
    localparam int G     = calc_groups(DEPTH, LANES);
    localparam int VW    = 2 * WIDTH + 1;

    typedef struct {
        int            ch;
        logic [VW-1:0] val;
    } sb_t;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [WIDTH-1:0] CYCLE [DEPTH];
    logic [WIDTH-1:0] DUTY  [DEPTH];
    logic [WIDTH-1:0] PHASE [DEPTH];
    logic [DEPTH-1:0] OVER;
    logic [WIDTH-1:0] LEFT  [DEPTH];
    logic [WIDTH-1:0] RIGHT [DEPTH];

    sb_t           sb[$];
    logic [VW-1:0] cur_out [DEPTH];
    int            vec  = 0;
    int            errs = 0;
    int            n;

    pwm_edge_calc_mc_if ctl ();

    pwm_edge_calc_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ctl   (ctl),
        .CYCLE (CYCLE),
        .DUTY  (DUTY),
        .PHASE (PHASE),
        .OVER  (OVER),
        .LEFT  (LEFT),
        .RIGHT (RIGHT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] model(input int cyc, input int duty, input int ph, input bit mode);
        int s, d, l, r;
        bit o;
        d = duty;
`ifdef PWM_DUTY_CLAMP_EN
        if (d > cyc) d = cyc;
`endif
        s = (ph > 0 && ph < cyc) ? cyc - ph : 0;
        if (mode) begin
            l = s;
            r = s + d;
        end else begin
            l = s - d / 2;
            r = s + (d + 1) / 2;
        end
        o = 1'b0;
        if (cyc == 0) begin
            l = 0;
            r = 0;
        end else if (l < 0) begin
            l = l + cyc;
            o = 1'b1;
        end else if (r >= cyc) begin
            r = r - cyc;
            o = 1'b1;
        end
        return {o, l[WIDTH-1:0], r[WIDTH-1:0]};
    endfunction

    task automatic push_expected(input bit mode);
        for (int ch = 0; ch < DEPTH; ch++)
            sb.push_back('{ch, model(int'(CYCLE[ch]), int'(DUTY[ch]), int'(PHASE[ch]), mode)});
    endtask

    task automatic set_ch(input int ch, input int c, input int d, input int p);
        CYCLE[ch] = WIDTH'(c);
        DUTY[ch]  = WIDTH'(d);
        PHASE[ch] = WIDTH'(p);
    endtask

    task automatic rand_ch(input int ch);
        int c;
        c = int'($urandom_range(8191, 1));
        set_ch(ch, c, int'($urandom_range(c, 0)), int'($urandom_range(8191, 0)));
    endtask

    // Starts in the first cycle after the UPDATE edge; returns the cycle index of DONE.
    task automatic wait_done(input string tag, input bit poke, output int cnt);
        int busy_n;
        int diff;
        busy_n = 0;
        cnt = 1;
        while (ctl.DONE !== 1'b1 && cnt < 200) begin
            if (ctl.BUSY === 1'b1) busy_n++;
            if (cnt == G + 3) begin
                diff = 0;
                for (int ch = 0; ch < DEPTH; ch++)
                    if ({OVER[ch], LEFT[ch], RIGHT[ch]} !== cur_out[ch]) diff++;
                chk({tag, "_hold_before_done"}, 32'(diff), 0);
            end
            if (poke && cnt == 10) begin
                ctl.UPDATE = 1'b1;
                ctl.MODE   = ~ctl.MODE;
            end else if (poke && cnt == 11) begin
                ctl.UPDATE = 1'b0;
                ctl.MODE   = ~ctl.MODE;
            end
            tick();
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), G + 4);
        chk({tag, "_busy_cycles"}, 32'(busy_n), G + 3);
        chk({tag, "_busy_at_done"}, 32'(ctl.BUSY), 0);
    endtask

    task automatic check_commit(input string tag);
        sb_t e;
        chk({tag, "_sb_depth"}, 32'(sb.size()), DEPTH);
        for (int k = 0; k < DEPTH && sb.size() > 0; k++) begin
            e = sb.pop_front();
            chk($sformatf("%s_ch%0d", tag, e.ch), 32'({OVER[e.ch], LEFT[e.ch], RIGHT[e.ch]}), 32'(e.val));
            cur_out[e.ch] = e.val;
        end
    endtask

    initial begin
        int nz;
        ctl.UPDATE = 1'b0;
        ctl.MODE   = MODE_CENTER;
        RST_N      = 1'b0;
        for (int ch = 0; ch < DEPTH; ch++) begin
            set_ch(ch, 0, 0, 0);
            cur_out[ch] = '0;
        end
        tick();
        tick();
        chk("rst_busy", 32'(ctl.BUSY), 0);
        chk("rst_done", 32'(ctl.DONE), 0);
        chk("rst_over_any", 32'(|OVER), 0);
        chk("rst_left0", 32'(LEFT[0]), 0);
        RST_N = 1'b1;
        tick();

        for (int ch = 0; ch < DEPTH; ch++) rand_ch(ch);
        set_ch(0, 4096, 2048, 2048);
        set_ch(1, 4096, 2048, 0);
        set_ch(2, 100, 7, 50);
        set_ch(3, 100, 70, 40);
        set_ch(4, 500, 0, 123);
        set_ch(5, 0, 0, 77);
        set_ch(7, 300, 31, 300);
        set_ch(8, 8191, 8191, 1);
`ifdef PWM_DUTY_CLAMP_EN
        set_ch(6, 100, 150, 50);
`else
        set_ch(6, 100, 100, 0);
`endif

        // Centre mode with an ignored UPDATE poke mid-run.
        push_expected(MODE_CENTER);
        ctl.MODE   = MODE_CENTER;
        ctl.UPDATE = 1'b1;
        tick();
        ctl.UPDATE = 1'b0;
        wait_done("centre", 1'b1, n);
        check_commit("centre");
        chk("c_ch0_left", 32'(LEFT[0]), 1024);
        chk("c_ch0_right", 32'(RIGHT[0]), 3072);
        chk("c_ch0_over", 32'(OVER[0]), 0);
        chk("c_ch1_left", 32'(LEFT[1]), 3072);
        chk("c_ch1_right", 32'(RIGHT[1]), 1024);
        chk("c_ch1_over", 32'(OVER[1]), 1);
        chk("c_ch2_left", 32'(LEFT[2]), 47);
        chk("c_ch2_right", 32'(RIGHT[2]), 54);
        chk("c_ch4_duty0", 32'({LEFT[4], RIGHT[4]}), 32'({13'd377, 13'd377}));
        chk("c_ch5_cyc0", 32'({OVER[5], LEFT[5], RIGHT[5]}), 0);
`ifdef PWM_DUTY_CLAMP_EN
        chk("c_ch6_clamp", 32'({OVER[6], LEFT[6], RIGHT[6]}), 32'({1'b1, 13'd0, 13'd0}));
`endif
        tick();
        chk("done_pulse_width", 32'(ctl.DONE), 0);
        chk("poke_not_queued", 32'(ctl.BUSY), 0);

        // Leading-edge mode.
        push_expected(MODE_LEAD);
        ctl.MODE   = MODE_LEAD;
        ctl.UPDATE = 1'b1;
        tick();
        ctl.UPDATE = 1'b0;
        wait_done("lead", 1'b0, n);
        check_commit("lead");
        chk("l_ch3_left", 32'(LEFT[3]), 60);
        chk("l_ch3_right", 32'(RIGHT[3]), 30);
        chk("l_ch3_over", 32'(OVER[3]), 1);

        // UPDATE held high restarts right after the commit.
        ctl.MODE = MODE_CENTER;
        tick();
        push_expected(MODE_CENTER);
        ctl.UPDATE = 1'b1;
        tick();
        wait_done("held1", 1'b0, n);
        check_commit("held1");
        for (int ch = 10; ch < 30; ch++) rand_ch(ch);
        set_ch(DEPTH - 1, 1000, 400, 900);
        push_expected(MODE_CENTER);
        tick();
        chk("held_restart_busy", 32'(ctl.BUSY), 1);
        ctl.UPDATE = 1'b0;
        wait_done("held2", 1'b0, n);
        check_commit("held2");

        // Reset in the middle of RUN aborts without committing.
        for (int ch = 0; ch < DEPTH; ch += 3) rand_ch(ch);
        push_expected(MODE_CENTER);
        ctl.UPDATE = 1'b1;
        tick();
        ctl.UPDATE = 1'b0;
        repeat (20) tick();
        RST_N = 1'b0;
        #1;
        nz = 0;
        for (int ch = 0; ch < DEPTH; ch++)
            if (LEFT[ch] !== '0 || RIGHT[ch] !== '0) nz++;
        chk("midrst_busy", 32'(ctl.BUSY), 0);
        chk("midrst_done", 32'(ctl.DONE), 0);
        chk("midrst_edges_nonzero", 32'(nz), 0);
        chk("midrst_over_any", 32'(|OVER), 0);
        sb.delete();
        for (int ch = 0; ch < DEPTH; ch++) cur_out[ch] = '0;
        tick();
        RST_N = 1'b1;
        tick();
        chk("postrst_busy", 32'(ctl.BUSY), 0);
        chk("postrst_done", 32'(ctl.DONE), 0);

        push_expected(MODE_CENTER);
        ctl.UPDATE = 1'b1;
        tick();
        ctl.UPDATE = 1'b0;
        wait_done("after_rst", 1'b0, n);
        check_commit("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/pwm_edge_calc_mc.md
Name: pwm_edge_calc_mc

Overview:
- Multi-lane, double-buffered successor of the per-transducer PWM edge preconditioner.
- On an UPDATE it snapshots per-channel cycle/duty/phase, then computes fold-wrapped rise (LEFT) and fall (RIGHT) edges plus an OVER (wrap) flag for every channel.
- LANES channels are processed per clock through a 3-stage pipeline.
- All outputs commit atomically, so downstream PWM generators never see a half-updated table.
- Sits between the register/normal-operation bank and the per-transducer PWM generators.

Parameters:
- WIDTH, 13, bit width of cycle/duty/phase/edges.
- DEPTH, 249, number of channels (transducers).
- LANES, 4, channels processed per clock; 1 <= LANES <= DEPTH.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- UPDATE  in  1  start request; sampled only when idle.
- MODE  in  1  0 = centre-aligned, 1 = leading-edge-aligned; sampled with UPDATE.
- CYCLE  in  [WIDTH-1:0] x DEPTH  period per channel.
- DUTY  in  [WIDTH-1:0] x DEPTH  on-time per channel.
- PHASE  in  [WIDTH-1:0] x DEPTH  phase per channel.
- BUSY  out  1  high while a computation is in flight.
- DONE  out  1  one-cycle pulse when new outputs commit.
- OVER  out  1 x DEPTH  pulse wraps the period boundary.
- LEFT  out  [WIDTH-1:0] x DEPTH  rise edge, in [0, CYCLE-1].
- RIGHT  out  [WIDTH-1:0] x DEPTH  fall edge, in [0, CYCLE-1].

Behaviour:
- Reset (async, RST_N low):
  - State -> IDLE; BUSY=0, DONE=0.
  - All OVER/LEFT/RIGHT and shadow registers -> 0; snapshot registers -> 0.
  - Reset mid-computation aborts it; no partial commit.
- FSM states:
  - IDLE: UPDATE=1 snapshots CYCLE/DUTY/PHASE/MODE, goes to RUN, and sets BUSY=1 from the next cycle.
  - RUN: issues group g = 0..G-1, with G = ceil(DEPTH/LANES), one group per clock. Lanes with index >= DEPTH in the last group are discarded. After the final group retires from the pipeline, go to COMMIT.
  - COMMIT: copy shadow -> OVER/LEFT/RIGHT in one edge, assert DONE for that cycle, BUSY=0, return to IDLE.
- UPDATE while BUSY is ignored; no queueing. UPDATE held high restarts the computation immediately after COMMIT.
- Latency: UPDATE edge to DONE high = G + 4 cycles (1 issue + 3 pipeline + commit). BUSY is high for exactly G + 3 cycles.
- Pipeline, per channel, arithmetic signed WIDTH+2 bits:
  - S1: s = CYCLE-PHASE if 0 < PHASE < CYCLE, else 0. dh = floor(d/2); dl = ceil(d/2).
  - S2, MODE=0: l = s - dh; r = s + dl.
  - S2, MODE=1: l = s; r = s + d.
  - S3 fold: if l < 0, l += CYCLE and OVER=1. Else if r >= CYCLE, r -= CYCLE and OVER=1. Else OVER=0. The result written to shadow is the low WIDTH bits.
- Boundary cases:
  - DUTY=0: LEFT=RIGHT=s, OVER=0.
  - CYCLE=0: LEFT=RIGHT=0, OVER=0.
  - DUTY > CYCLE: see the optional feature.
  - Outputs keep previous values until DONE.

Optional Feature:
- Macro: PWM_DUTY_CLAMP_EN.
- Defined: S1 uses d = min(DUTY, CYCLE).
- Undefined: d = DUTY unmodified. When DUTY > CYCLE the fold is applied once only and the result is unspecified but deterministic; the bench skips that case.

Decomposition:
- Package pwm_calc_pkg holds:
  - typedef for the FSM state enum;
  - constants PIPE_LATENCY = 3 and MODE_CENTER/MODE_LEAD;
  - a function computing G from DEPTH and LANES.
- Sub-module pwm_edge_lane: one lane, the 3-stage S1-S3 pipeline. It is instantiated LANES times; the top level keeps the FSM, group counter, snapshot, shadow and commit.

Test Plan:
- Centre mode, CYCLE=4096, DUTY=2048, PHASE=2048 -> LEFT=1024, RIGHT=3072, OVER=0; DONE at UPDATE+G+4.
- Centre mode, CYCLE=4096, DUTY=2048, PHASE=0 -> s=0, LEFT=3072, RIGHT=1024, OVER=1.
- Centre mode, CYCLE=100, DUTY=7, PHASE=50 -> LEFT=47, RIGHT=54, OVER=0 (odd-duty rounding).
- Lead mode, CYCLE=100, DUTY=70, PHASE=40 -> LEFT=60, RIGHT=30, OVER=1.
- DEPTH=249, LANES=4 -> BUSY high for 66 cycles. A second UPDATE during BUSY is ignored. Outputs are unchanged until the DONE cycle, then all 249 channels update together.
- RST_N low mid-RUN -> BUSY=0, outputs all 0, no DONE. A fresh UPDATE completes normally. With PWM_DUTY_CLAMP_EN: CYCLE=100, DUTY=150, PHASE=50, centre -> LEFT=0, RIGHT=0, OVER=1.
